// File: rtl/hc_serial_rx.sv
// rtl/hc_serial_rx.sv - serial Hamming(7,4) receiver: sync framing, decode, 1-deep output, error stats
module hc_serial_rx #(
  parameter int CNT_W   = 16,
  parameter bit CORRECT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bit_vld,
  input  logic             i_bit,
  input  logic             i_sync,
  input  logic             i_clr,
  output logic [3:0]       o_data,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_ovf
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [5:0]       bits_q, bits_d;
  logic             word_done;

  logic [6:0]       cw, cw_fix;
  logic [2:0]       syn;
  logic [3:0]       nib;

  logic             vld_q, vld_d;
  logic [3:0]       data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             ovf_q, ovf_d;
  logic             load, drop;

  // Framing: bits_q[k] holds codeword position k+1; a sync always restarts the word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    word_done = 1'b0;
    if (i_bit_vld) begin
      if (i_sync) begin
        bits_d  = {5'b0, i_bit};
        cnt_d   = 3'd1;
        state_d = ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
        if (cnt_q == 3'd6) begin
          word_done = 1'b1;
          cnt_d     = 3'd0;
          state_d   = ST_IDLE;
        end else begin
          bits_d[cnt_q] = i_bit;
          cnt_d         = cnt_q + 3'd1;
        end
      end
    end
  end

  always_comb begin
    cw     = {i_bit, bits_q};
    syn    = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
              cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
              cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    cw_fix = cw;
    // Flipping a parity position is harmless: only positions 3,5,6,7 reach the nibble.
    if (CORRECT && (syn != 3'd0)) begin
      cw_fix[syn - 3'd1] = ~cw[syn - 3'd1];
    end
    nib = {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
  end

  always_comb begin
    load   = word_done && (!vld_q || i_rdy);
    drop   = word_done && vld_q && !i_rdy;
    vld_d  = vld_q;
    data_d = data_q;
    err_d  = err_q;
    ecnt_d = ecnt_q;
    ovf_d  = ovf_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = nib;
      err_d  = (syn != 3'd0);
    end else if (vld_q && i_rdy) begin
      vld_d = 1'b0;
    end
    if (i_clr) begin
      ecnt_d = '0;
    end else if (word_done && (syn != 3'd0) && (ecnt_q != {CNT_W{1'b1}})) begin
      ecnt_d = ecnt_q + 1'b1;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      bits_q  <= 6'd0;
      vld_q   <= 1'b0;
      data_q  <= 4'd0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_vld     = vld_q;
  assign o_data    = data_q;
  assign o_err     = err_q;
  assign o_err_cnt = ecnt_q;
  assign o_ovf     = ovf_q;

endmodule
